// File: rtl/dpram_port_arbiter_if.sv
// Bundle of both requester channels and the bank-0 port-0 RAM signals.
// The arbiter takes the slave view; the requester/RAM side takes the master view.
interface dpram_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  req_a;
    logic                  we_a;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [DATA_WIDTH-1:0] wdata_a;
    logic                  gnt_a;
    logic                  rvalid_a;
    logic [DATA_WIDTH-1:0] rdata_a;

    logic                  req_b;
    logic                  we_b;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] wdata_b;
    logic                  gnt_b;
    logic                  rvalid_b;
    logic [DATA_WIDTH-1:0] rdata_b;

    logic [ADDR_WIDTH-1:0] addr0_b0;
    logic                  ce0_b0;
    logic                  we0_b0;
    logic [DATA_WIDTH-1:0] d0_b0;
    logic [DATA_WIDTH-1:0] q0_b0;

    modport master (
        output req_a, we_a, addr_a, wdata_a,
        output req_b, we_b, addr_b, wdata_b,
        output q0_b0,
        input  gnt_a, rvalid_a, rdata_a,
        input  gnt_b, rvalid_b, rdata_b,
        input  addr0_b0, ce0_b0, we0_b0, d0_b0
    );

    modport slave (
        input  req_a, we_a, addr_a, wdata_a,
        input  req_b, we_b, addr_b, wdata_b,
        input  q0_b0,
        output gnt_a, rvalid_a, rdata_a,
        output gnt_b, rvalid_b, rdata_b,
        output addr0_b0, ce0_b0, we0_b0, d0_b0
    );
endinterface

// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing RAM bank 0 port 0 between requesters A and B,
// with a read tag pipeline steering returned data back to the issuing side.
module dpram_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RD_LATENCY = 1
) (
    input logic                  clk,
    input logic                  reset,
    dpram_port_arbiter_if.slave  bus
);
    localparam int LAST = RD_LATENCY;

    logic                  gnt_a;
    logic                  gnt_b;

    logic                  last_b_q, last_b_d;
    logic                  ce_q, ce_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wd_q, wd_d;
    logic [LAST:0]         tag_vld_q, tag_vld_d;
    logic [LAST:0]         tag_id_q, tag_id_d;
    logic                  rvalid_a_q, rvalid_a_d;
    logic                  rvalid_b_q, rvalid_b_d;
    logic [DATA_WIDTH-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_WIDTH-1:0] rdata_b_q, rdata_b_d;

    // A wins unless B is also requesting and A was the last one served.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!reset) begin
            if (bus.req_a && (!bus.req_b || last_b_q)) begin
                gnt_a = 1'b1;
            end else if (bus.req_b) begin
                gnt_b = 1'b1;
            end
        end
    end

    always_comb begin
        last_b_d   = last_b_q;
        ce_d       = 1'b0;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wd_d       = wd_q;
        rvalid_a_d = 1'b0;
        rvalid_b_d = 1'b0;
        rdata_a_d  = rdata_a_q;
        rdata_b_d  = rdata_b_q;

        if (gnt_a) begin
            ce_d     = 1'b1;
            we_d     = bus.we_a;
            addr_d   = bus.addr_a;
            wd_d     = bus.wdata_a;
            last_b_d = 1'b0;
        end else if (gnt_b) begin
            ce_d     = 1'b1;
            we_d     = bus.we_b;
            addr_d   = bus.addr_b;
            wd_d     = bus.wdata_b;
            last_b_d = 1'b1;
        end

        // Stage 0 records reads only; id bit set means requester B.
        tag_vld_d = {tag_vld_q[LAST-1:0], (gnt_a & ~bus.we_a) | (gnt_b & ~bus.we_b)};
        tag_id_d  = {tag_id_q[LAST-1:0], gnt_b};

        if (tag_vld_q[LAST]) begin
            if (tag_id_q[LAST]) begin
                rvalid_b_d = 1'b1;
                rdata_b_d  = bus.q0_b0;
            end else begin
                rvalid_a_d = 1'b1;
                rdata_a_d  = bus.q0_b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_b_q   <= 1'b1;
            ce_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wd_q       <= '0;
            tag_vld_q  <= '0;
            tag_id_q   <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
        end else begin
            last_b_q   <= last_b_d;
            ce_q       <= ce_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wd_q       <= wd_d;
            tag_vld_q  <= tag_vld_d;
            tag_id_q   <= tag_id_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
        end
    end

    assign bus.gnt_a    = gnt_a;
    assign bus.gnt_b    = gnt_b;
    assign bus.rvalid_a = rvalid_a_q;
    assign bus.rvalid_b = rvalid_b_q;
    assign bus.rdata_a  = rdata_a_q;
    assign bus.rdata_b  = rdata_b_q;
    assign bus.addr0_b0 = addr_q;
    assign bus.ce0_b0   = ce_q;
    assign bus.we0_b0   = we_q;
    assign bus.d0_b0    = wd_q;

endmodule
